morse_decoder: RTL and testbench
================================

# morse_decoder

Serial Morse receiver that sits directly downstream of the Morse letter encoder. It consumes the encoder's one-bit dot/dash line and measures mark and space run lengths in symbol slots. From those runs it rebuilds the element pattern and reports the 3-bit letter code (A–H, same code map as the encoder) with a one-cycle valid or error pulse per received letter.

## Interface
- TICK_DIV, 250: Clock1 cycles per symbol slot; must match the encoder's slot rate, minimum 4, even.
- MAX_ELEMS, 4: maximum dots/dashes per letter.

Ports:
- Clock1  in  1  system clock.
- Reset1  in  1  reset; asynchronous, active-low.
- DotDashIn  in  1  serial Morse line; 1 = mark, 0 = space; asynchronous to slot phase.
- LetterOut  out  3  decoded letter code; holds last valid value; reset 3'b000.
- LetterValid  out  1  one-cycle pulse, LetterOut updated same cycle; reset 0.
- LetterError  out  1  one-cycle pulse for a malformed or unknown letter; reset 0.
- Busy  out  1  high whenever state ≠ IDLE; reset 0.

## Operation
- **Input synchroniser:** DotDashIn passes through a 2-flop synchroniser, giving `din_s`. All logic uses `din_s`.
- **Line format:**
  - dot = 1 mark slot; dash = 3 mark slots.
  - Intra-letter gap = 1 space slot; letter end = 3 space slots.
- **Code map:**
  - A 000 = .-, B 001 = -..., C 010 = -.-., D 011 = -..
  - E 100 = ., F 101 = ..-., G 110 = --., H 111 = ....
- **Slot timer:**
  - Down-counter, width $clog2(TICK_DIV).
  - Held in IDLE.
  - On the IDLE rising edge of `din_s`, it loads TICK_DIV/2−1, so samples land mid-slot.
  - Afterwards it reloads TICK_DIV−1 at zero.
  - `tick` = counter==0 while not IDLE.
- **FSM:**
  - IDLE: wait for a `din_s` 0→1 edge. Then go to MARK with run=0, elems=0, pattern cleared, err=0.
  - MARK, on tick:
    - if din_s=1, run = run+1, saturating at 7.
    - if din_s=0: a run of 1 shifts in 0 (dot); a run of 3 shifts in 1 (dash); any other run sets err.
    - Then elems+1; elems > MAX_ELEMS sets err (count saturates).
    - Go to SPACE with run=1.
  - SPACE, on tick:
    - if din_s=1, go to MARK with run=1.
    - if din_s=0, run+1. When run reaches 3, go to EMIT.
  - EMIT, one cycle:
    - if err=0 and (elems, pattern) matches the map, drive LetterOut and pulse LetterValid.
    - otherwise pulse LetterError; LetterOut is unchanged.
    - Then go to IDLE.
- Extra space slots after the letter end are ignored (IDLE).
- A mark run of 2 or ≥4 is an error, reported only at EMIT. There is exactly one event per letter.
- Pattern register: MAX_ELEMS bits, shifted in MSB-first order of arrival; the match uses elems plus the pattern.
- **Reset mid-letter:** state, counters, pattern and outputs go immediately to reset values. No pulse is emitted.

## Timing
- Input to `din_s` latency: 2 cycles.
- First sample: TICK_DIV/2 cycles after the `din_s` rise. Then every TICK_DIV cycles.
- LetterValid/LetterError: asserted 1 cycle after the tick that samples the third consecutive space slot.
- Pulses are never simultaneous, never longer than one cycle, and never closer together than 3·TICK_DIV cycles.
- Back-to-back letters: a new mark edge is accepted from the first IDLE cycle after EMIT.

## Structure
- Package `morse_pkg` holds:
  - letter code localparams (LTR_A..LTR_H)
  - element encodings (DOT=0, DASH=1)
  - the pattern/length table
  - the FSM state enum
  - default TICK_DIV
- Sub-module `morse_slot_timer` (Clock1, Reset1, align, run, tick) implements the aligned slot counter. The decoder FSM lives in the top module.

## Test plan
All scenarios use TICK_DIV=4.
- **Letter A:** drive 1,0,1,1,1,0,0,0, one value per 4 cycles → single LetterValid, LetterOut=000, Busy low afterwards.
- **Full sweep:** all eight letters back-to-back, each followed by 3 space slots → codes 000..111 in order; no LetterError.
- **Bad mark:** 2-slot mark then 3 spaces → LetterError once, LetterValid never, LetterOut keeps its previous value.
- **Too many elements:** 5 dots (H plus one) → LetterError. Valid pattern outside the map (e.g. "--") → LetterError.
- **Reset mid-letter:** pulse Reset1 low during the second element of B → all outputs 0 immediately, no pulse; next letter E decodes to 100.
- **Phase offset:** edges offset by 1 and 3 cycles from slot alignment, plus a 1-cycle glitch inside a space slot → correct decode; glitches shorter than a slot that miss the sample point are ignored.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver: letter codes, element encodings,
// the pattern/length table used for matching, and the decoder state type.
package morse_pkg;

  localparam int TICK_DIV_DEF  = 250;
  localparam int MAX_ELEMS_DEF = 4;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Entry i describes letter code i; patterns are right-aligned, first element highest.
  localparam logic [7:0][2:0] TBL_LEN = {3'd4, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd4, 3'd2};
  localparam logic [7:0][3:0] TBL_PAT = {4'b0000, 4'b0110, 4'b0010, 4'b0000,
                                         4'b0100, 4'b1010, 4'b1000, 4'b0001};

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

endpackage

// File: rtl/morse_decoder_if.sv
// Line-side and letter-side signals of the Morse receiver.
interface morse_decoder_if;
  logic       DotDashIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       LetterError;
  logic       Busy;

  modport master (output DotDashIn, input LetterOut, LetterValid, LetterError, Busy);
  modport slave  (input DotDashIn, output LetterOut, LetterValid, LetterError, Busy);
endinterface

// File: rtl/morse_slot_timer.sv
// Slot down-counter: aligned half a slot after a mark edge so ticks land mid-slot.
module morse_slot_timer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic Clock1,
  input  logic Reset1,
  input  logic align,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_p0;

  always_ff @(posedge Clock1 or negedge Reset1) begin
    if (!Reset1) begin
      cnt_p0 <= '0;
    end else if (align) begin
      cnt_p0 <= CW'(TICK_DIV / 2 - 1);
    end else if (run) begin
      cnt_p0 <= (cnt_p0 == '0) ? CW'(TICK_DIV - 1) : cnt_p0 - CW'(1);
    end
  end

  assign tick = run && (cnt_p0 == '0);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space run lengths in slots, rebuilds the element
// pattern and reports one valid or error pulse per letter.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int MAX_ELEMS = MAX_ELEMS_DEF
) (
  input logic            Clock1,
  input logic            Reset1,
  morse_decoder_if.slave bus
);

  localparam int EW = $clog2(MAX_ELEMS + 2);
  localparam int PW = MAX_ELEMS;

  logic          din_p0, din_s, din_d;
  state_t        state;
  logic [2:0]    run;
  logic [EW-1:0] elems;
  logic [PW-1:0] pattern;
  logic          err;
  logic [2:0]    letter_q;
  logic          valid_q, error_q;
  logic          align, tick;
  logic          hit;
  logic [2:0]    hit_code;

  function automatic logic [2:0] run_inc(input logic [2:0] r);
    return (r == 3'd7) ? r : r + 3'd1;
  endfunction

  function automatic logic [EW-1:0] elems_inc(input logic [EW-1:0] e);
    return (e == EW'(MAX_ELEMS + 1)) ? e : e + EW'(1);
  endfunction

  // Stage p0/s: two-flop synchroniser, then a delayed copy for edge detection
  always_ff @(posedge Clock1 or negedge Reset1) begin
    if (!Reset1) begin
      din_p0 <= 1'b0;
      din_s  <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      din_p0 <= bus.DotDashIn;
      din_s  <= din_p0;
      din_d  <= din_s;
    end
  end

  assign align = (state == IDLE) && din_s && !din_d;

  morse_slot_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .Clock1 (Clock1),
    .Reset1 (Reset1),
    .align  (align),
    .run    (state != IDLE),
    .tick   (tick)
  );

  always_comb begin
    hit      = 1'b0;
    hit_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elems == EW'(TBL_LEN[i]) && pattern == PW'(TBL_PAT[i])) begin
        hit      = 1'b1;
        hit_code = 3'(i);
      end
    end
  end

  // Pulses are raised on the transition into EMIT so they appear during the EMIT cycle
  always_ff @(posedge Clock1 or negedge Reset1) begin
    if (!Reset1) begin
      state    <= IDLE;
      run      <= 3'd0;
      elems    <= '0;
      pattern  <= '0;
      err      <= 1'b0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (din_s && !din_d) begin
            state   <= MARK;
            run     <= 3'd0;
            elems   <= '0;
            pattern <= '0;
            err     <= 1'b0;
          end
        end
        MARK: begin
          if (tick) begin
            if (din_s) begin
              run <= run_inc(run);
            end else begin
              if (run == 3'd1)      pattern <= {pattern[PW-2:0], DOT};
              else if (run == 3'd3) pattern <= {pattern[PW-2:0], DASH};
              else                  err <= 1'b1;
              if (elems >= EW'(MAX_ELEMS)) err <= 1'b1;
              elems <= elems_inc(elems);
              state <= SPACE;
              run   <= 3'd1;
            end
          end
        end
        SPACE: begin
          if (tick) begin
            if (din_s) begin
              state <= MARK;
              run   <= 3'd1;
            end else begin
              run <= run_inc(run);
              if (run == 3'd2) begin
                state <= EMIT;
                if (!err && hit) begin
                  letter_q <= hit_code;
                  valid_q  <= 1'b1;
                end else begin
                  error_q <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.LetterOut   = letter_q;
  assign bus.LetterValid = valid_q;
  assign bus.LetterError = error_q;
  assign bus.Busy        = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder at TICK_DIV=4: expected letter events are
// queued as each letter is sent and matched against valid/error pulses.
module tb_morse_decoder;
  localparam int TD = 4;

  typedef struct packed {
    logic       is_err;
    logic [2:0] out;
  } exp_t;

  logic Clock1 = 1'b0;
  logic Reset1 = 1'b0;
  morse_decoder_if bus();

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [2:0] last_code = 3'd0;
  logic prev_pulse = 1'b0;

  string pats [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  always #5 Clock1 = ~Clock1;

  morse_decoder #(.TICK_DIV(TD), .MAX_ELEMS(4)) dut (
    .Clock1 (Clock1),
    .Reset1 (Reset1),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic v, input int cycles);
    bus.DotDashIn = v;
    repeat (cycles) begin
      @(posedge Clock1);
      #1;
    end
  endtask

  // '.' dot, '-' dash, '2' illegal two-slot mark; optional glitch in an end space
  task automatic send_pat(input string p, input logic is_err, input logic [2:0] code,
                          input logic glitch, input int trail);
    exp_t e;
    for (int i = 0; i < p.len(); i++) begin
      if (i > 0) send(1'b0, TD);
      if (p[i] == "-")      send(1'b1, 3 * TD);
      else if (p[i] == "2") send(1'b1, 2 * TD);
      else                  send(1'b1, TD);
    end
    if (!is_err) last_code = code;
    e.is_err = is_err;
    e.out    = last_code;
    q.push_back(e);
    send(1'b0, TD);
    if (glitch) begin
      send(1'b1, 1);
      send(1'b0, TD - 1);
    end else begin
      send(1'b0, TD);
    end
    send(1'b0, TD);
    send(1'b0, trail * TD);
  endtask

  always @(negedge Clock1) begin
    if (Reset1 && (bus.LetterValid || bus.LetterError)) begin
      exp_t e;
      chk("excl", 32'(bus.LetterValid & bus.LetterError), 0);
      chk("width", 32'(prev_pulse), 0);
      if (q.size() == 0) begin
        chk("unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("valid", 32'(bus.LetterValid), 32'(!e.is_err));
        chk("error", 32'(bus.LetterError), 32'(e.is_err));
        chk("letter", 32'(bus.LetterOut), 32'(e.out));
      end
    end
    prev_pulse = bus.LetterValid | bus.LetterError;
  end

  initial begin
    bus.DotDashIn = 1'b0;
    repeat (3) @(posedge Clock1);
    #1;
    chk("rst_out",   32'(bus.LetterOut), 0);
    chk("rst_valid", 32'(bus.LetterValid), 0);
    chk("rst_error", 32'(bus.LetterError), 0);
    chk("rst_busy",  32'(bus.Busy), 0);
    Reset1 = 1'b1;
    send(1'b0, 3 * TD);

    // Letter A, then Busy must drop
    bus.DotDashIn = 1'b1;
    repeat (4) begin @(posedge Clock1); #1; end
    chk("busy_mid", 32'(bus.Busy), 1);
    send(1'b0, TD);
    send(1'b1, 3 * TD);
    q.push_back('{is_err: 1'b0, out: 3'd0});
    last_code = 3'd0;
    send(1'b0, 3 * TD);
    send(1'b0, 2 * TD);
    chk("busy_after", 32'(bus.Busy), 0);
    chk("out_A", 32'(bus.LetterOut), 0);

    // Full sweep back-to-back
    for (int i = 0; i < 8; i++) send_pat(pats[i], 1'b0, 3'(i), 1'b0, 0);
    send(1'b0, 3 * TD);

    // Malformed letters keep the previous code
    send_pat("2", 1'b1, 3'd0, 1'b0, 1);
    chk("keep_out", 32'(bus.LetterOut), 32'(last_code));
    send_pat(".....", 1'b1, 3'd0, 1'b0, 1);
    send_pat("--", 1'b1, 3'd0, 1'b0, 1);
    send_pat("-.2", 1'b1, 3'd0, 1'b0, 1);

    // Reset during the second element of B
    send(1'b1, 3 * TD);
    send(1'b0, TD);
    send(1'b1, 2);
    Reset1 = 1'b0;
    bus.DotDashIn = 1'b0;
    #1;
    chk("mid_rst_out",   32'(bus.LetterOut), 0);
    chk("mid_rst_busy",  32'(bus.Busy), 0);
    chk("mid_rst_valid", 32'(bus.LetterValid), 0);
    chk("mid_rst_error", 32'(bus.LetterError), 0);
    last_code = 3'd0;
    send(1'b0, 3);
    Reset1 = 1'b1;
    send(1'b0, 4 * TD);
    send_pat(".", 1'b0, 3'd4, 1'b0, 1);
    chk("post_rst_E", 32'(bus.LetterOut), 4);

    // Phase offsets and a short glitch inside an end space slot
    send(1'b0, 1);
    send_pat("-.-.", 1'b0, 3'd2, 1'b1, 1);
    send(1'b0, 3);
    send_pat("--.", 1'b0, 3'd6, 1'b1, 1);
    send(1'b0, 2);
    send_pat("..-.", 1'b0, 3'd5, 1'b0, 1);

    send(1'b0, 10 * TD);
    chk("pending", 32'(q.size()), 0);
    chk("final_busy", 32'(bus.Busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
